// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the monster-lane spawn scheduler.
// Holds the FSM encodings, lane indices and the lane-pick LFSR tap mask.
// Imported by the scheduler top and its LFSR sub-module.
package nexys_starship_pkg;

  localparam int NUM_LANES = 4;

  // One-hot controller states; the bits drive q_Init/q_Play/q_Over directly.
  typedef enum logic [2:0] {
    ST_INIT = 3'b001,
    ST_PLAY = 3'b010,
    ST_OVER = 3'b100
  } state_t;

  localparam int LANE_TOP    = 0;
  localparam int LANE_BOTTOM = 1;
  localparam int LANE_LEFT   = 2;
  localparam int LANE_RIGHT  = 3;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic lfsr_feedback(input logic [7:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick the first lane to try for a spawn.
// Latency: new value every Clk edge; reloads SEED only on Reset.
// No backpressure: it shifts every cycle regardless of game state.
module nexys_starship_lfsr8
  import nexys_starship_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [1:0] pick
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift left, feedback into bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
  end

  // State register; seed is restored only by the hard reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign pick = lfsr_q[1:0];

endmodule

// File: rtl/nexys_starship_monster_sched.sv
// Spawn scheduler and per-lane attack timers for four monster lanes; optional macro NEXYS_STARSHIP_DIFFICULTY_EN.
// Latency: every output is a flop, updated on the Clk edge that samples tick/kill/play_flag.
// No backpressure: spawn is a one-cycle pulse; full lanes just hold the spawn retry at gap 1.
module nexys_starship_monster_sched
  import nexys_starship_pkg::*;
#(
  parameter int unsigned SPAWN_GAP    = 4,
  parameter int unsigned ATTACK_TICKS = 8,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 tick,
  input  logic                 play_flag,
  input  logic [NUM_LANES-1:0] kill,
  output logic [NUM_LANES-1:0] spawn,
  output logic [NUM_LANES-1:0] monster,
  output logic                 game_over,
  output logic                 q_Init,
  output logic                 q_Play,
  output logic                 q_Over
);

  localparam logic [3:0] GAP_INIT = 4'(SPAWN_GAP);
  localparam logic [3:0] ATK_INIT = 4'(ATTACK_TICKS);

  state_t                          state_q, state_d;
  logic [NUM_LANES-1:0]            spawn_q, spawn_d;
  logic [NUM_LANES-1:0]            monster_q, monster_d;
  logic [NUM_LANES-1:0][3:0]       timer_q, timer_d;
  logic                            game_over_q, game_over_d;
  logic [3:0]                      gap_q, gap_d;
  logic [1:0]                      pick;
  logic [NUM_LANES-1:0]            kill_acc;
  logic [NUM_LANES-1:0]            spawn_oh;
  logic                            found;
  logic                            expire;
  logic [1:0]                      idx;
  logic [3:0]                      reload;

  nexys_starship_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .pick  (pick)
  );

  // Kills only count against occupied lanes while playing.
  assign kill_acc = (state_q == ST_PLAY) ? (kill & monster_q) : '0;

  // First empty lane starting at the LFSR pick, using start-of-cycle occupancy.
  always_comb begin
    spawn_oh = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = pick + 2'(k);
      if (!found && !monster_q[idx]) begin
        spawn_oh[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // A timer expires on a 1->0 tick unless the same lane is killed this cycle.
  always_comb begin
    expire = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (tick && monster_q[i] && (timer_q[i] == 4'd1) && !kill_acc[i]) expire = 1'b1;
    end
  end

`ifdef NEXYS_STARSHIP_DIFFICULTY_EN
  logic [2:0] kcnt_q, kcnt_d;
  logic [3:0] reload_q, reload_d;
  logic [3:0] ksum;

  // Every eighth accepted kill shortens the spawn gap by one, never below 1.
  always_comb begin
    kcnt_d   = kcnt_q;
    reload_d = reload_q;
    ksum     = {1'b0, kcnt_q} + 4'($countones(kill_acc));
    if (state_d == ST_INIT) begin
      kcnt_d   = '0;
      reload_d = GAP_INIT;
    end else begin
      kcnt_d = ksum[2:0];
      if (ksum[3] && (reload_q > 4'd1)) reload_d = reload_q - 4'd1;
    end
  end

  // Difficulty registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      kcnt_q   <= '0;
      reload_q <= GAP_INIT;
    end else begin
      kcnt_q   <= kcnt_d;
      reload_q <= reload_d;
    end
  end

  assign reload = reload_q;
`else
  assign reload = GAP_INIT;
`endif

  // Next-state and output logic for the INIT/PLAY/OVER controller.
  always_comb begin
    state_d     = state_q;
    spawn_d     = '0;
    monster_d   = monster_q;
    timer_d     = timer_q;
    game_over_d = game_over_q;
    gap_d       = gap_q;
    case (state_q)
      ST_INIT: begin
        monster_d   = '0;
        timer_d     = '0;
        game_over_d = 1'b0;
        gap_d       = GAP_INIT;
        if (play_flag) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (monster_q[i]) timer_d[i] = timer_q[i] - 4'd1;
          end
          if (gap_q > 4'd1) gap_d = gap_q - 4'd1;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
          if (kill_acc[i]) begin
            monster_d[i] = 1'b0;
            timer_d[i]   = '0;
          end
        end
        // Ending the game takes precedence over a spawn attempt on the same tick.
        if (expire) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
        end else if (tick && (gap_q == 4'd1) && found) begin
          spawn_d   = spawn_oh;
          monster_d = monster_d | spawn_oh;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (spawn_oh[i]) timer_d[i] = ATK_INIT;
          end
          gap_d = reload;
        end
      end
      ST_OVER: begin
        game_over_d = 1'b1;
        if (!play_flag) begin
          state_d     = ST_INIT;
          monster_d   = '0;
          timer_d     = '0;
          game_over_d = 1'b0;
          gap_d       = GAP_INIT;
        end
      end
      default: begin
        state_d     = ST_INIT;
        monster_d   = '0;
        timer_d     = '0;
        game_over_d = 1'b0;
        gap_d       = GAP_INIT;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      spawn_q     <= '0;
      monster_q   <= '0;
      timer_q     <= '0;
      game_over_q <= 1'b0;
      gap_q       <= GAP_INIT;
    end else begin
      state_q     <= state_d;
      spawn_q     <= spawn_d;
      monster_q   <= monster_d;
      timer_q     <= timer_d;
      game_over_q <= game_over_d;
      gap_q       <= gap_d;
    end
  end

  assign spawn     = spawn_q;
  assign monster   = monster_q;
  assign game_over = game_over_q;
  assign q_Init    = state_q[0];
  assign q_Play    = state_q[1];
  assign q_Over    = state_q[2];

endmodule

// File: tb/tb_nexys_starship_monster_sched.sv
// Directed bench for the monster spawn scheduler (two instances: default and long-timer/fast-spawn).
// Inputs change #1 after a rising edge; outputs are sampled #1 after the edge that registers them.
// Spawn lanes are predicted from an independent LFSR model started at the reset seed.
module tb_nexys_starship_monster_sched;

  localparam logic [2:0] S_INIT = 3'b001;
  localparam logic [2:0] S_PLAY = 3'b010;
  localparam logic [2:0] S_OVER = 3'b100;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       tick_a = 1'b0, play_a = 1'b0;
  logic [3:0] kill_a = 4'h0;
  logic [3:0] spawn_a, monster_a;
  logic       go_a, qi_a, qp_a, qo_a;
  logic       tick_b = 1'b0, play_b = 1'b0;
  logic [3:0] kill_b = 4'h0;
  logic [3:0] spawn_b, monster_b;
  logic       go_b, qi_b, qp_b, qo_b;

  nexys_starship_monster_sched u_dut_a (
    .Clk(Clk), .Reset(Reset), .tick(tick_a), .play_flag(play_a), .kill(kill_a),
    .spawn(spawn_a), .monster(monster_a), .game_over(go_a),
    .q_Init(qi_a), .q_Play(qp_a), .q_Over(qo_a)
  );

  nexys_starship_monster_sched #(.SPAWN_GAP(1), .ATTACK_TICKS(15)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .tick(tick_b), .play_flag(play_b), .kill(kill_b),
    .spawn(spawn_b), .monster(monster_b), .game_over(go_b),
    .q_Init(qi_b), .q_Play(qp_b), .q_Over(qo_b)
  );

  always #5 Clk = ~Clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] lfsr_m  = 8'hA5;
  logic [1:0] lane_at_edge;

  typedef struct {
    logic       tk;
    logic       pl;
    logic [3:0] kl;
    logic       sp;
    logic       go;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] first_empty(input logic [1:0] start, input logic [3:0] occ);
    logic [3:0] r;
    logic [1:0] i;
    r = 4'h0;
    for (int k = 0; k < 4; k++) begin
      i = start + 2'(k);
      if (r == 4'h0 && !occ[i]) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    lane_at_edge = lfsr_m[1:0];
    @(posedge Clk);
    if (!Reset) lfsr_m = lfsr_next(lfsr_m);
    #1;
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Reset  = 1'b0;
    lfsr_m = 8'hA5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_mon, fe, exp_sp, l1, l2, l3, mon_b;
    logic [2:0] prev_st;
    int         cnt;

    // tk pl kill sp go state
    vecs[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, S_INIT};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_INIT};
    vecs[2]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, S_PLAY};
    vecs[3]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[7]  = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0, S_PLAY};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, S_PLAY};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[14] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_PLAY};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, S_OVER};
    vecs[17] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b1, S_OVER};
    vecs[18] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, S_OVER};
    vecs[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, S_INIT};
    vecs[20] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_INIT};

    // Reset state of both instances.
    #12;
    check("rst_spawn_a", spawn_a, 4'h0);
    check("rst_monster_a", monster_a, 4'h0);
    check("rst_go_a", go_a, 1'b0);
    check("rst_state_a", {qo_a, qp_a, qi_a}, S_INIT);
    check("rst_state_b", {qo_b, qp_b, qi_b}, S_INIT);
    release_reset();

    // Table: start, gap countdown, first spawn, expiry 8 ticks later, OVER, back to INIT.
    exp_mon = 4'h0;
    prev_st = S_INIT;
    for (int i = 0; i < 21; i++) begin
      tick_a = vecs[i].tk;
      play_a = vecs[i].pl;
      kill_a = vecs[i].kl;
      step();
      fe = first_empty(lane_at_edge, exp_mon);
      if (prev_st == S_PLAY) exp_mon = exp_mon & ~vecs[i].kl;
      exp_sp = vecs[i].sp ? fe : 4'h0;
      exp_mon = exp_mon | exp_sp;
      if (vecs[i].st == S_INIT) exp_mon = 4'h0;
      check($sformatf("vec%0d_spawn", i), spawn_a, exp_sp);
      check($sformatf("vec%0d_monster", i), monster_a, exp_mon);
      check($sformatf("vec%0d_go", i), go_a, vecs[i].go);
      check($sformatf("vec%0d_state", i), {qo_a, qp_a, qi_a}, vecs[i].st);
      prev_st = vecs[i].st;
    end
    tick_a = 1'b0; play_a = 1'b0; kill_a = 4'h0;

    // Kill coincident with expiry: kill wins, and the killed lane is not a spawn target.
    play_a = 1'b1;
    step();
    check("s2_enter_play", {qo_a, qp_a, qi_a}, S_PLAY);
    exp_mon = 4'h0;
    l1 = 4'h0;
    tick_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      fe = (i == 4) ? first_empty(lane_at_edge, 4'h0) : 4'h0;
      if (i == 4) l1 = fe;
      check($sformatf("s2_gap_spawn%0d", i), spawn_a, fe);
    end
    exp_mon = l1;
    l2 = 4'h0;
    for (int t = 1; t <= 7; t++) begin
      step();
      fe = (t == 4) ? first_empty(lane_at_edge, exp_mon) : 4'h0;
      if (t == 4) l2 = fe;
      exp_mon = exp_mon | fe;
      check($sformatf("s2_t%0d_spawn", t), spawn_a, fe);
    end
    check("s2_two_lanes", monster_a, l1 | l2);
    kill_a = l1;
    step();
    l3 = first_empty(lane_at_edge, exp_mon);
    exp_mon = (exp_mon & ~l1) | l3;
    check("s2_t8_spawn", spawn_a, l3);
    check("s2_t8_monster", monster_a, exp_mon);
    check("s2_t8_go", go_a, 1'b0);
    check("s2_t8_state", {qo_a, qp_a, qi_a}, S_PLAY);
    tick_a = 1'b0; kill_a = 4'h0;

    // Asynchronous reset mid-PLAY with two lanes occupied and a spawn pulse in flight.
    #2;
    Reset = 1'b1;
    #1;
    check("arst_spawn", spawn_a, 4'h0);
    check("arst_monster", monster_a, 4'h0);
    check("arst_go", go_a, 1'b0);
    check("arst_state", {qo_a, qp_a, qi_a}, S_INIT);
    play_a = 1'b0;
    release_reset();

    // Instance B: fill all lanes, hold while full, kill-then-respawn ordering.
    play_b = 1'b1;
    step();
    check("b_enter_play", {qo_b, qp_b, qi_b}, S_PLAY);
    mon_b = 4'h0;
    tick_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      fe = first_empty(lane_at_edge, mon_b);
      mon_b = mon_b | fe;
      check($sformatf("b_fill%0d_spawn", i), spawn_b, fe);
      check($sformatf("b_fill%0d_monster", i), monster_b, mon_b);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("b_full%0d_spawn", i), spawn_b, 4'h0);
      check($sformatf("b_full%0d_monster", i), monster_b, 4'hF);
    end
    tick_b = 1'b0; kill_b = 4'b0100;
    step();
    check("b_kill_notick_spawn", spawn_b, 4'h0);
    check("b_kill_notick_monster", monster_b, 4'b1011);
    tick_b = 1'b1; kill_b = 4'h0;
    step();
    check("b_refill_spawn", spawn_b, 4'b0100);
    check("b_refill_monster", monster_b, 4'hF);
    kill_b = 4'b0001;
    step();
    check("b_kill_tick_spawn", spawn_b, 4'h0);
    check("b_kill_tick_monster", monster_b, 4'b1110);
    kill_b = 4'h0;
    step();
    check("b_next_tick_spawn", spawn_b, 4'b0001);
    check("b_next_tick_monster", monster_b, 4'hF);
    check("b_go", go_b, 1'b0);
    check("b_state", {qo_b, qp_b, qi_b}, S_PLAY);
    tick_b = 1'b0; play_b = 1'b0;

`ifdef NEXYS_STARSHIP_DIFFICULTY_EN
    // Spawn interval shrinks by one every 8 kills, floor 1.
    #2;
    Reset = 1'b1;
    release_reset();
    play_a = 1'b1;
    step();
    for (int n = 1; n <= 34; n++) begin
      cnt = 0;
      tick_a = 1'b1;
      do begin
        step();
        cnt++;
      end while (spawn_a == 4'h0 && cnt < 20);
      tick_a = 1'b0;
      if (n == 1) check("diff_first_interval", cnt, 4);
      else check($sformatf("diff_interval%0d", n), cnt, ((n - 2) / 8 >= 3) ? 1 : 4 - (n - 2) / 8);
      kill_a = spawn_a;
      step();
      kill_a = 4'h0;
    end
    play_a = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nexys_starship_monster_sched.md
Name: nexys_starship_monster_sched

Overview:
- Central spawn scheduler and attack-timer controller for the four monster lanes: top, bottom, left, right.
- Decides when and where a monster appears, tracks per-lane attack timers, clears lanes on kills and raises game_over on any timer expiry.
- Sits between the game-state/input logic (play_flag, kill events) and the per-lane display and monster FSMs, which consume spawn/monster.

Parameters:
- SPAWN_GAP, 4: ticks between spawn attempts; range 1..15.
- ATTACK_TICKS, 8: ticks a monster survives before it ends the game; range 1..15.
- LFSR_SEED, 8'hA5: reset value of the lane-pick LFSR; must be nonzero.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle game-time enable; all timers advance only when tick=1
- play_flag  in  1  level; game start request
- kill  in  4  per-lane kill pulse, bit0=top, 1=bottom, 2=left, 3=right
- spawn  out  4  one-hot, one-cycle spawn pulse
- monster  out  4  lane-occupied flags
- game_over  out  1  level; sticky until return to INIT
- q_Init, q_Play, q_Over  out  1 each  one-hot state outputs

Behaviour:
- Reset, and every entry to INIT: spawn=0, monster=0, game_over=0, all attack timers=0, gap_cnt=SPAWN_GAP, state=INIT. The LFSR resets to LFSR_SEED only on Reset.
- All outputs are registered and update on the Clk edge that samples tick (or the other inputs). There are no combinational outputs.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every cycle in all states.
- INIT -> PLAY when play_flag=1. gap_cnt is loaded with SPAWN_GAP on entry to PLAY.
- PLAY, on each tick:
  - gap_cnt>1: decrement gap_cnt.
  - gap_cnt==1: attempt a spawn. Start the search at lane LFSR[1:0] and take the first empty lane, ascending modulo 4.
  - On a successful spawn: pulse spawn[i], set monster[i], load timer[i]=ATTACK_TICKS, reload gap_cnt=SPAWN_GAP.
  - All four lanes full: no spawn; gap_cnt holds at 1 and the spawn is retried on the next tick.
- Attack timers, on each tick: every occupied lane not spawned on this tick decrements its timer. Expiry is a decrement from 1 to 0 with no kill on that lane in the same cycle. Expiry sets game_over=1 and moves to OVER.
- Kill rules:
  - kill[i] with monster[i]=1 clears monster[i] and timer[i] in that cycle, regardless of tick.
  - kill[i] on an empty lane is ignored.
- Simultaneous events:
  - Kill and expiry on the same lane in the same cycle: the kill wins and there is no game over.
  - Kill and spawn search in the same cycle: eligibility uses occupancy at the start of the cycle, so a lane killed this cycle is not eligible for spawn until the next tick.
  - Expiry on one lane while another lane is killed: OVER.
- OVER: no spawns; timers frozen; kill ignored; game_over=1. OVER -> INIT when play_flag=0.
- Reset mid-operation returns to INIT immediately; no pulse is completed.
- Unreachable state encoding -> INIT.

Optional Feature:
- NEXYS_STARSHIP_DIFFICULTY_EN defined:
  - A 3-bit kill counter counts accepted kills.
  - On each wrap (8 kills), the effective gap reload value decrements by 1, floor 1.
  - The effective reload value returns to SPAWN_GAP on entry to INIT.
- Undefined: the reload value is always SPAWN_GAP and the kill counter is absent.

Decomposition:
- Shared package nexys_starship_pkg holds:
  - state encodings: INIT=3'b001, PLAY=3'b010, OVER=3'b100
  - lane indices: TOP=0, BOTTOM=1, LEFT=2, RIGHT=3
  - NUM_LANES=4
  - LFSR tap constant
- Sub-module nexys_starship_lfsr8: free-running LFSR with seed parameter and a Reset input. Everything else stays in this module.

Test Plan:
- Reset, play_flag=1, 4 ticks -> q_Play after 1 cycle; exactly one spawn pulse on the 4th tick; that monster bit set; lane = first empty from LFSR[1:0].
- Spawn and no kill -> game_over=1 and q_Over on the 8th tick after the spawn tick; no further spawn pulses.
- kill[i] on the 8th tick after spawn[i], coincident with expiry -> monster[i]=0, game_over stays 0, PLAY continues.
- Fill all 4 lanes with kills held off; ATTACK_TICKS=15 -> no spawn while full, gap_cnt held at 1; one kill -> spawn into that lane on the next tick, not the same cycle.
- Reset asserted mid-PLAY with 2 lanes occupied -> monster=0, spawn=0, game_over=0, q_Init=1 asynchronously; play_flag=0 in OVER -> INIT, outputs cleared.
- With NEXYS_STARSHIP_DIFFICULTY_EN and SPAWN_GAP=4: after 8 kills, spawn interval is 3 ticks; after 24 kills it is 1, and it stays 1 after 32 kills.
